// File: rtl/key_sw_conditioner.sv
// Input conditioning for the Run pushbutton and slide switches: two-flop
// synchronisers, debounce windows and one-cycle event strobes for the SoC PIOs.
module key_sw_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SW_WIDTH        = 8
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                key_run_n_raw,
    input  logic [SW_WIDTH-1:0] sw_raw,
    output logic                run_n,
    output logic                run_press,
    output logic                run_release,
    output logic [SW_WIDTH-1:0] sw_out,
    output logic                sw_changed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } key_state_t;

    // Key synchroniser idles high so an unpressed button never looks pressed.
    logic [1:0] key_sync_reg;
    logic       ks;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_sync_reg <= 2'b11;
        end else begin
            key_sync_reg <= {key_sync_reg[0], key_run_n_raw};
        end
    end

    assign ks = key_sync_reg[1];

    logic [SW_WIDTH-1:0] ss;

    genvar gi;
    generate
        for (gi = 0; gi < SW_WIDTH; gi++) begin : g_sw_sync
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= sw_raw[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign ss[gi] = sync_reg;
        end
    endgenerate

    // Key debounce FSM
    key_state_t       state_reg, state_next;
    logic [CNT_W-1:0] kcnt_reg, kcnt_next;
    logic             run_n_reg, run_n_next;
    logic             run_press_reg, run_press_next;
    logic             run_release_reg, run_release_next;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg       <= RELEASED;
            kcnt_reg        <= CNT_ZERO;
            run_n_reg       <= 1'b1;
            run_press_reg   <= 1'b0;
            run_release_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            kcnt_reg        <= kcnt_next;
            run_n_reg       <= run_n_next;
            run_press_reg   <= run_press_next;
            run_release_reg <= run_release_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        kcnt_next        = kcnt_reg;
        run_n_next       = run_n_reg;
        run_press_next   = 1'b0;
        run_release_next = 1'b0;
        case (state_reg)
            RELEASED: begin
                if (!ks) begin
                    state_next = PRESS_WAIT;
                    kcnt_next  = CNT_ONE;
                end else begin
                    kcnt_next  = CNT_ZERO;
                end
            end
            PRESS_WAIT: begin
                if (ks) begin
                    state_next = RELEASED;
                    kcnt_next  = CNT_ZERO;
                end else if (kcnt_reg == CNT_LAST) begin
                    state_next     = PRESSED;
                    run_n_next     = 1'b0;
                    run_press_next = 1'b1;
                end else begin
                    kcnt_next = kcnt_reg + CNT_ONE;
                end
            end
            PRESSED: begin
                if (ks) begin
                    state_next = RELEASE_WAIT;
                    kcnt_next  = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (!ks) begin
                    state_next = PRESSED;
                    kcnt_next  = CNT_ZERO;
                end else if (kcnt_reg == CNT_LAST) begin
                    state_next       = RELEASED;
                    run_n_next       = 1'b1;
                    run_release_next = 1'b1;
                end else begin
                    kcnt_next = kcnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = RELEASED;
                kcnt_next  = CNT_ZERO;
            end
        endcase
    end

    // Whole-bus window: any bit change restarts it, so multi-bit moves land atomically.
    logic [SW_WIDTH-1:0] scand_reg;
    logic [CNT_W-1:0]    scnt_reg;
    logic [SW_WIDTH-1:0] sw_out_reg;
    logic                sw_changed_reg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            scand_reg      <= '0;
            scnt_reg       <= CNT_ZERO;
            sw_out_reg     <= '0;
            sw_changed_reg <= 1'b0;
        end else begin
            sw_changed_reg <= 1'b0;
            if (ss != scand_reg) begin
                scand_reg <= ss;
                scnt_reg  <= CNT_ONE;
            end else if (scnt_reg < CNT_LAST) begin
                scnt_reg <= scnt_reg + CNT_ONE;
            end else if (scand_reg != sw_out_reg) begin
                sw_out_reg     <= scand_reg;
                sw_changed_reg <= 1'b1;
            end
        end
    end

    assign run_n       = run_n_reg;
    assign run_press   = run_press_reg;
    assign run_release = run_release_reg;
    assign sw_out      = sw_out_reg;
    assign sw_changed  = sw_changed_reg;

endmodule
